// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Wait-counter width able to hold TIMEOUT itself.
    function automatic int unsigned wait_cnt_w(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_buf.sv
// Tagged result register: holds one transfer result until the consumer takes it.
module mem_arb_buf
    import mem_arb_pkg::*;
#(
    parameter int unsigned TAG_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill,
    input  logic              clear,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic [TAG_W-1:0]  cmp_tag,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic             valid;
    logic [TAG_W-1:0] tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid & (tag == cmp_tag);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store traffic onto one ready-handshake memory port
// and raises the pipeline stall requests while results are outstanding.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    localparam int unsigned      CNT_W   = wait_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t        state, state_nxt;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic              d_pend, i_pend, done, issue_d, issue_i;

    assign d_pend = d_req & ~d_valid;
    assign i_pend = if_req & ~if_valid;
    assign done   = mem_req & mem_ready;

    assign mem_req   = (state != IDLE);
    assign mem_we    = req_we;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    // Gated so that every output reads 0 while reset is held.
    assign stall_if  = reset & i_pend;
    assign stall_mem = reset & d_pend;

    always_comb begin
        state_nxt = state;
        issue_d   = 1'b0;
        issue_i   = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_pend) begin
                    issue_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_pend) begin
                    issue_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (issue_d) begin
            req_we    <= d_we;
            req_addr  <= d_addr;
            req_wdata <= d_wdata;
        end else if (issue_i) begin
            req_we    <= 1'b0;
            req_addr  <= if_addr;
            req_wdata <= '0;
        end else if (done) begin
            req_we    <= 1'b0;
        end
    end

    // Watchdog only flags a stuck transfer; the transfer itself keeps waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (state == IDLE || mem_ready) wait_cnt <= '0;
            else if (wait_cnt != CNT_MAX)   wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_MAX) bus_err <= 1'b1;
        end
    end

    mem_arb_buf #(
        .TAG_W (ADDR_W),
        .DATA_W(DATA_W)
    ) u_ibuf (
        .clk      (clk),
        .reset    (reset),
        .fill     (done & (state == BUSY_I)),
        .clear    (if_ack & if_valid),
        .fill_tag (req_addr),
        .fill_data(mem_rdata),
        .cmp_tag  (if_addr),
        .hit      (if_valid),
        .data     (if_rdata)
    );

    // Data results are not address-matched: a constant tag makes hit == valid.
    mem_arb_buf #(
        .TAG_W (1),
        .DATA_W(DATA_W)
    ) u_dbuf (
        .clk      (clk),
        .reset    (reset),
        .fill     (done & (state == BUSY_D)),
        .clear    (d_ack & d_valid),
        .fill_tag (1'b0),
        .fill_data(mem_rdata),
        .cmp_tag  (1'b0),
        .hit      (d_valid),
        .data     (d_rdata)
    );

endmodule
